enemy_controller: RTL and testbench

Sequencing FSM for one enemy instance: drives the enemy datapath's reset/update strobes, picks a pseudo-random spawn column, and shares the single pixel plotter through a request/done handshake for the erase-move-redraw cycle. It sits between the game top level (start, hit detection, scoring) and one enemy datapath plus the shared VGA plotter.

---
 rtl/enemy_controller.sv | 141 ++++++++++++++
 tb/tb_enemy_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_controller.sv
// Sequencer for one enemy: spawn, erase/move/redraw through the shared plotter,
// kill and bottom handling, with a frame-rate move timer and a spawn-column LFSR.
module enemy_controller #(
    parameter int unsigned FRAME_DIV       = 833333,
    parameter int unsigned FRAMES_PER_MOVE = 4,
    parameter int unsigned X_MAX           = 151,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       hit,
    input  logic       bottomReached,
    input  logic       draw_done,
    output logic       inResetState,
    output logic       inUpdatePositionState,
    output logic [7:0] enemyXIn,
    output logic       draw_req,
    output logic       erase,
    output logic       score_inc,
    output logic       miss
);

    localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned MW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [MW-1:0] MOVE_LAST  = MW'(FRAMES_PER_MOVE - 1);
    localparam logic [7:0]    X_LIMIT    = 8'(X_MAX);
    localparam logic [7:0]    X_SPAN     = 8'(X_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_DRAW, S_WAIT, S_ERASE, S_UPDATE, S_CHECK
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [MW-1:0]   move_q, move_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [7:0]      enemy_x_q, enemy_x_d;
    logic            kill_q, kill_d;
    logic            move_pend_q, move_pend_d;
    logic            score_inc_q, score_inc_d;
    logic            miss_q, miss_d;

    logic frame_tick, move_tick, kill_now, pend_clr;
    logic [7:0] spawn_x;

    // A hit in the same cycle as a decision counts, so kill beats bottomReached in CHECK.
    assign kill_now   = kill_q | (hit & (state_q != S_IDLE) & (state_q != S_SPAWN));
    assign frame_tick = (state_q != S_IDLE) && (frame_q == FRAME_LAST);
    assign move_tick  = frame_tick && (move_q == MOVE_LAST);
    assign spawn_x    = (lfsr_q <= X_LIMIT) ? lfsr_q : lfsr_q - X_SPAN;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        score_inc_d = 1'b0;
        miss_d      = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SPAWN;
            S_SPAWN:  state_d = S_DRAW;
            S_DRAW:   if (draw_done) state_d = S_WAIT;
            S_WAIT: begin
                if (!start)                         state_d = S_IDLE;
                else if (kill_now || move_pend_q)   state_d = S_ERASE;
            end
            S_ERASE: begin
                if (draw_done) begin
                    if (kill_now) begin
                        state_d     = S_SPAWN;
                        score_inc_d = 1'b1;
                    end else begin
                        state_d = S_UPDATE;
                    end
                end
            end
            S_UPDATE: state_d = S_CHECK;
            S_CHECK: begin
                if (kill_now) begin
                    state_d     = S_SPAWN;
                    score_inc_d = 1'b1;
                end else if (bottomReached) begin
                    state_d = S_SPAWN;
                    miss_d  = 1'b1;
                end else begin
                    state_d = S_DRAW;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_d = '0;
        move_d  = '0;
        if (state_q != S_IDLE) begin
            frame_d = frame_tick ? '0 : frame_q + FW'(1);
            move_d  = move_q;
            if (frame_tick) move_d = move_tick ? '0 : move_q + MW'(1);
        end
        pend_clr    = (state_q == S_SPAWN) || ((state_q == S_WAIT) && (state_d == S_ERASE));
        move_pend_d = (move_pend_q & ~pend_clr) | move_tick;
        kill_d      = (state_q == S_SPAWN) ? 1'b0 : kill_now;
        enemy_x_d   = (state_q == S_SPAWN) ? spawn_x : enemy_x_q;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            move_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            enemy_x_q   <= '0;
            kill_q      <= 1'b0;
            move_pend_q <= 1'b0;
            score_inc_q <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            move_q      <= move_d;
            lfsr_q      <= lfsr_d;
            enemy_x_q   <= enemy_x_d;
            kill_q      <= kill_d;
            move_pend_q <= move_pend_d;
            score_inc_q <= score_inc_d;
            miss_q      <= miss_d;
        end
    end

    assign inResetState          = (state_q == S_IDLE) || (state_q == S_SPAWN);
    assign inUpdatePositionState = (state_q == S_UPDATE);
    assign draw_req              = (state_q == S_DRAW) || (state_q == S_ERASE);
    assign erase                 = (state_q == S_ERASE);
    assign enemyXIn              = enemy_x_q;
    assign score_inc             = score_inc_q;
    assign miss                  = miss_q;

endmodule

// File: tb/tb_enemy_controller.sv
// Bench for enemy_controller: cycle table for spawn/first move, then an event
// scoreboard over move, bottom, kill, stop/restart and async-reset sequences.
module tb_enemy_controller;

    localparam logic [7:0] SEED = 8'hFF;

    logic       clk = 1'b0;
    logic       resetn, start, hit, bottomReached, draw_done;
    logic       inResetState, inUpdatePositionState, draw_req, erase, score_inc, miss;
    logic [7:0] enemyXIn;

    enemy_controller #(
        .FRAME_DIV(4), .FRAMES_PER_MOVE(2), .X_MAX(151), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .hit(hit),
        .bottomReached(bottomReached), .draw_done(draw_done),
        .inResetState(inResetState), .inUpdatePositionState(inUpdatePositionState),
        .enemyXIn(enemyXIn), .draw_req(draw_req), .erase(erase),
        .score_inc(score_inc), .miss(miss)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_DRAW, EV_ERASE, EV_UPD, EV_SCORE, EV_MISS} ev_e;
    typedef struct packed {
        logic       start;
        logic       hit;
        logic       bot;
        logic       done;
        logic [5:0] exp;   // {inResetState, draw_req, erase, upd, score_inc, miss}
    } vec_t;

    ev_e        sb_q[$];
    int         er_cyc[$];
    vec_t       tv[14];
    int         tests = 0, fails = 0, cyc = 0, pcnt = 0;
    bit         auto_plot = 1'b0;
    logic [7:0] tb_lfsr, prev_lfsr, first_x;
    logic       p_req, p_rst, p_erase;
    int         start_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] v);
        return (v > 8'd151) ? v - 8'd152 : v;
    endfunction

    task automatic post_event(input ev_e e);
        ev_e exp_e;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got event %0d expected none", int'(e));
        end else begin
            exp_e = sb_q.pop_front();
            check("sb_event_order", int'(e), int'(exp_e));
        end
    endtask

    // One clock: sample just after the edge, observe events, then run the plotter model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        prev_lfsr = tb_lfsr;
        tb_lfsr   = lfsr_step(tb_lfsr);
        if (draw_req && !p_req) begin
            post_event(erase ? EV_ERASE : EV_DRAW);
            if (erase) er_cyc.push_back(cyc);
        end
        if (draw_req && p_req) check("erase_stable", erase, p_erase);
        if (inUpdatePositionState) post_event(EV_UPD);
        if (score_inc) post_event(EV_SCORE);
        if (miss) post_event(EV_MISS);
        if (p_rst && !inResetState) check("spawn_x", enemyXIn, clamp(prev_lfsr));
        p_req   = draw_req;
        p_rst   = inResetState;
        p_erase = erase;
        if (auto_plot) begin
            if (draw_done) begin
                draw_done = 1'b0;
                pcnt      = 0;
            end else if (draw_req) begin
                pcnt++;
                if (pcnt >= 2) draw_done = 1'b1;
            end else begin
                pcnt = 0;
            end
        end
    endtask

    task automatic wait_upd(input string name);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (inUpdatePositionState) break;
        end
        check(name, inUpdatePositionState, 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick();
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0]  = {1'b1, 1'b0, 1'b0, 1'b0, 6'b100000};  // IDLE -> SPAWN
        tv[1]  = {1'b1, 1'b0, 1'b0, 1'b0, 6'b010000};  // DRAW
        tv[2]  = {1'b1, 1'b0, 1'b0, 1'b0, 6'b010000};
        tv[3]  = {1'b1, 1'b0, 1'b0, 1'b1, 6'b000000};  // WAIT
        for (int i = 4; i <= 8; i++) tv[i] = {1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
        tv[9]  = {1'b1, 1'b0, 1'b0, 1'b0, 6'b011000};  // ERASE after first move tick
        tv[10] = {1'b1, 1'b0, 1'b0, 1'b1, 6'b000100};  // UPDATE
        tv[11] = {1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};  // CHECK
        tv[12] = {1'b1, 1'b0, 1'b0, 1'b0, 6'b010000};  // redraw
        tv[13] = {1'b1, 1'b0, 1'b0, 1'b1, 6'b000000};  // WAIT

        resetn = 1'b0; start = 1'b0; hit = 1'b0; bottomReached = 1'b0; draw_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {inResetState, draw_req, erase, inUpdatePositionState, score_inc, miss},
              6'b100000);
        check("reset_x", enemyXIn, 8'h00);
        @(negedge clk);
        resetn  = 1'b1;
        tb_lfsr = SEED;
        p_req = 1'b0; p_rst = 1'b1; p_erase = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_hold", {inResetState, draw_req, enemyXIn}, {1'b1, 1'b0, 8'h00});
        end
        for (int i = 0; i < 50; i++) begin
            if (lfsr_step(tb_lfsr) > 8'd151) break;
            tick();
        end
        first_x = lfsr_step(tb_lfsr) - 8'd152;

        sb_q.push_back(EV_DRAW); sb_q.push_back(EV_ERASE);
        sb_q.push_back(EV_UPD);  sb_q.push_back(EV_DRAW);
        for (int i = 0; i < 14; i++) begin
            start = tv[i].start; hit = tv[i].hit; bottomReached = tv[i].bot; draw_done = tv[i].done;
            tick();
            check($sformatf("vec%0d", i),
                  {inResetState, draw_req, erase, inUpdatePositionState, score_inc, miss}, tv[i].exp);
            if (i == 1) check("clamp_first", enemyXIn, first_x);
        end
        check("table_sb", sb_q.size(), 0);
        draw_done = 1'b0;
        auto_plot = 1'b1;

        // Steady move cycles, one every 8 clocks
        repeat (2) begin
            sb_q.push_back(EV_ERASE); sb_q.push_back(EV_UPD); sb_q.push_back(EV_DRAW);
        end
        drain("move_drain");
        check("move_period_1", er_cyc[1] - er_cyc[0], 8);
        check("move_period_2", er_cyc[2] - er_cyc[1], 8);

        // Bottom reached: miss only, respawn
        sb_q.push_back(EV_ERASE); sb_q.push_back(EV_UPD);
        sb_q.push_back(EV_MISS);  sb_q.push_back(EV_DRAW);
        wait_upd("bottom_upd_seen");
        bottomReached = 1'b1;
        tick();
        check("bottom_check_quiet", {draw_req, inUpdatePositionState, inResetState}, 3'b000);
        tick();
        check("bottom_spawn", {inResetState, miss, score_inc}, 3'b110);
        bottomReached = 1'b0;
        tick();
        check("bottom_redraw", {draw_req, erase, inResetState, miss}, 4'b1000);

        // Hit during DRAW: erase then credited kill, no position update
        sb_q.push_back(EV_ERASE); sb_q.push_back(EV_SCORE); sb_q.push_back(EV_DRAW);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (score_inc) break;
        end
        check("kill_spawn", {score_inc, inResetState, miss}, 3'b110);
        tick();
        check("kill_pulse_end", {score_inc, draw_req}, 2'b01);
        drain("kill_drain");

        // Hit and bottom together in CHECK: kill wins
        sb_q.push_back(EV_ERASE); sb_q.push_back(EV_UPD);
        sb_q.push_back(EV_SCORE); sb_q.push_back(EV_DRAW);
        wait_upd("both_upd_seen");
        tick();
        hit = 1'b1; bottomReached = 1'b1;
        tick();
        check("both_spawn", {inResetState, score_inc, miss}, 3'b110);
        hit = 1'b0; bottomReached = 1'b0;
        drain("both_drain");

        // Stop in WAIT, then restart: counters and pending move start fresh
        for (int i = 0; i < 20; i++) begin
            if (!draw_req) break;
            tick();
        end
        start = 1'b0;
        tick();
        check("stop_idle", {inResetState, draw_req}, 2'b10);
        repeat (4) tick();
        check("stop_idle_hold", {inResetState, draw_req, erase}, 3'b100);
        start = 1'b1;
        sb_q.push_back(EV_DRAW); sb_q.push_back(EV_ERASE);
        start_edge = cyc + 1;
        tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        drain("restart_drain");
        check("restart_erase_latency", er_cyc[er_cyc.size() - 1] - start_edge, 9);

        // Async reset in the middle of an erase request
        check("pre_reset_req", {draw_req, erase}, 2'b11);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", {draw_req, inResetState, erase}, 3'b010);
        check("async_reset_x", enemyXIn, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
